// File: rtl/real_mul_pkg.sv
// Shared Real_Mul datapath definitions: significand widths, multiplier FSM
// states and the rounding-mode encoding shared with rounding_module.
package real_mul_pkg;

    localparam int MW_SP = 24;
    localparam int MW_DP = 53;

    // Significand width including the hidden bit.
    function automatic int mant_width(input bit is_double);
        return is_double ? MW_DP : MW_SP;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic [1:0] RM_ZERO      = 2'b00;
    localparam logic [1:0] RM_PINF      = 2'b01;
    localparam logic [1:0] RM_NINF      = 2'b10;
    localparam logic [1:0] RM_NEAR_EVEN = 2'b11;

endpackage

// File: rtl/mantissa_seq_multiplier_if.sv
// Request/response bundle of the sequential significand multiplier.
interface mantissa_seq_multiplier_if
    import real_mul_pkg::*;
#(
    parameter bit IS_DOUBLE = 1'b0
);
    localparam int MW = mant_width(IS_DOUBLE);
    localparam int PW = 2 * MW;

    logic          start;
    logic [MW-1:0] a;
    logic [MW-1:0] b;
    logic          busy;
    logic          done;
    logic [PW-1:0] product;

    modport master (output start, a, b, input busy, done, product);
    modport slave  (input start, a, b, output busy, done, product);
endinterface

// File: rtl/mantissa_seq_multiplier.sv
// Radix-2 shift-add multiplier for unsigned significands. One partial
// product per cycle; the full double-width product is registered at the
// last step and held until the next completion.
module mantissa_seq_multiplier
    import real_mul_pkg::*;
#(
    parameter bit IS_DOUBLE = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    mantissa_seq_multiplier_if.slave  bus
);
    localparam int MW = mant_width(IS_DOUBLE);
    localparam int PW = 2 * MW;
    localparam int CW = $clog2(MW);
    localparam logic [CW-1:0] LAST_STEP = CW'(MW - 1);

    mul_state_e    state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] mcand;
    logic [MW-1:0] acc_hi;
    logic [MW-1:0] acc_lo;
    logic [MW-1:0] addend;
    logic [MW:0]   sum_c;
    logic [PW-1:0] step_val;
    logic          busy_r;
    logic          done_r;
    logic [PW-1:0] prod_r;

    // Conditional add of the multiplicand; the carry is kept as the new MSB.
    assign addend   = acc_lo[0] ? mcand : '0;
    assign sum_c    = {1'b0, acc_hi} + {1'b0, addend};
    assign step_val = {sum_c, acc_lo[MW-1:1]};

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.product = prod_r;

    // Control FSM plus accumulator/counter datapath with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            prod_r <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        mcand  <= bus.a;
                        acc_hi <= '0;
                        acc_lo <= bus.b;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= CALC;
                    end else begin
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    {acc_hi, acc_lo} <= step_val;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        prod_r <= step_val;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
